// File: rtl/rv_decode_ctrl_stage_if.sv
// rv_decode_ctrl_stage_if: fetch/execute handshake and registered decode bundle
interface rv_decode_ctrl_stage_if #(parameter int XLEN = 64);
  logic            in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc, out_pc;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic            out_reg_write, out_mem_read, out_mem_write, out_alu_src, out_mem_to_reg;
  logic            out_branch, out_jump, out_word_op, out_illegal;
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_funct3, out_funct7,
    output out_reg_write, out_mem_read, out_mem_write, out_alu_src, out_mem_to_reg,
    output out_branch, out_jump, out_word_op, out_illegal
  );
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_funct3, out_funct7,
    input  out_reg_write, out_mem_read, out_mem_write, out_alu_src, out_mem_to_reg,
    input  out_branch, out_jump, out_word_op, out_illegal
  );
endinterface

// File: rtl/rv_decode_ctrl_stage.sv
// rv_decode_ctrl_stage: registered decode stage with load-use interlock, flush and stall counter
module rv_decode_ctrl_stage #(
  parameter int XLEN      = 64,
  parameter bit SUPPORT_W = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rv_decode_ctrl_stage_if.slave bus,
  output logic [CNT_W-1:0]     stall_cnt
);
  // ctl = {reg_write, mem_read, mem_write, alu_src, mem_to_reg, branch, jump, word_op, illegal}
  localparam logic [8:0] ILL = 9'b000000001;
  logic [31:0]      ins;
  logic [6:0]       opc;
  logic [4:0]       rs1, rs2, rd;
  logic [8:0]       ctl;
  logic             uses_rs1, uses_rs2, hazard, in_ready, valid_q;
  logic [XLEN+33:0] bundle_d, bundle_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  assign ins = bus.in_instr;
  assign opc = ins[6:0];
  assign rd  = ins[11:7];
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];
  always_comb begin
    ctl = ILL;
    case (opc)
      7'b0110011: ctl = 9'b100000000;
      7'b0010011: ctl = 9'b100100000;
      7'b0011011: ctl = SUPPORT_W ? 9'b100100010 : ILL;
      7'b0111011: ctl = SUPPORT_W ? 9'b100000010 : ILL;
      7'b0000011: ctl = 9'b110110000;
      7'b0100011: ctl = 9'b001100000;
      7'b1100011: ctl = 9'b000001000;
      7'b0110111: ctl = 9'b100100000;
      7'b0010111: ctl = 9'b100100000;
      7'b1101111: ctl = 9'b100100100;
      7'b1100111: ctl = 9'b100100100;
      default:    ctl = ILL;
    endcase
    if (rd == 5'd0) ctl[8] = 1'b0;
  end
  assign uses_rs1 = !(opc inside {7'b0110111, 7'b0010111, 7'b1101111});
  assign uses_rs2 = opc inside {7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011};
  assign hazard = valid_q && bus.out_mem_read && (bus.out_rd != 5'd0) && bus.in_valid &&
                  ((uses_rs1 && rs1 == bus.out_rd) || (uses_rs2 && rs2 == bus.out_rd));
  assign in_ready = !bus.flush && !hazard && (!valid_q || bus.out_ready);
  assign bundle_d = {bus.in_pc, rs1, rs2, rd, ins[14:12], ins[31:25], ctl};
  assign cnt_d = (hazard && !bus.flush && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (bus.flush) valid_q <= 1'b0;
      else if (bus.in_valid && in_ready) begin
        valid_q  <= 1'b1;
        bundle_q <= bundle_d;
      end else if (bus.out_ready) valid_q <= 1'b0;
    end
  end
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign {bus.out_pc, bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_funct3, bus.out_funct7,
          bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_alu_src, bus.out_mem_to_reg,
          bus.out_branch, bus.out_jump, bus.out_word_op, bus.out_illegal} = bundle_q;
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_rv_decode_ctrl_stage.sv
// tb_rv_decode_ctrl_stage: table vectors and hand sequences checked through an expected-output queue
module tb_rv_decode_ctrl_stage;
  localparam int XLEN = 64;
  localparam int CNT_W = 4;
  typedef struct { logic [31:0] instr; logic [8:0] c0, c1; } vec_t;
  typedef struct { logic [XLEN-1:0] pc; logic [31:0] instr; logic [8:0] c0, c1; } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CNT_W-1:0] sc0, sc1;
  logic [8:0] ctl0, ctl1;
  int n_vec = 0;
  int n_bad = 0;
  exp_t sb[$];
  exp_t me;
  vec_t tbl[14];
  always #5 clk = ~clk;
  rv_decode_ctrl_stage_if #(.XLEN(XLEN)) b0();
  rv_decode_ctrl_stage_if #(.XLEN(XLEN)) b1();
  assign b1.in_valid  = b0.in_valid;
  assign b1.in_instr  = b0.in_instr;
  assign b1.in_pc     = b0.in_pc;
  assign b1.flush     = b0.flush;
  assign b1.out_ready = b0.out_ready;
  rv_decode_ctrl_stage #(.XLEN(XLEN), .SUPPORT_W(1'b0), .CNT_W(CNT_W)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave), .stall_cnt(sc0));
  rv_decode_ctrl_stage #(.XLEN(XLEN), .SUPPORT_W(1'b1), .CNT_W(CNT_W)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave), .stall_cnt(sc1));
  assign ctl0 = {b0.out_reg_write, b0.out_mem_read, b0.out_mem_write, b0.out_alu_src, b0.out_mem_to_reg,
                 b0.out_branch, b0.out_jump, b0.out_word_op, b0.out_illegal};
  assign ctl1 = {b1.out_reg_write, b1.out_mem_read, b1.out_mem_write, b1.out_alu_src, b1.out_mem_to_reg,
                 b1.out_branch, b1.out_jump, b1.out_word_op, b1.out_illegal};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [XLEN-1:0] pc);
    b0.in_valid = 1'b1;
    b0.in_instr = instr;
    b0.in_pc    = pc;
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic [XLEN-1:0] pc,
                              input logic [8:0] c0, input logic [8:0] c1);
    exp_t e;
    e.pc = pc; e.instr = instr; e.c0 = c0; e.c1 = c1;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && b0.out_valid && b0.out_ready) begin
      if (sb.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_out: got pc %0h expected no output", b0.out_pc);
      end else begin
        me = sb.pop_front();
        check("out_pc", b0.out_pc, me.pc);
        check("fields", {b0.out_rs1, b0.out_rs2, b0.out_rd, b0.out_funct3, b0.out_funct7},
              {me.instr[19:15], me.instr[24:20], me.instr[11:7], me.instr[14:12], me.instr[31:25]});
        check("ctl_w0", ctl0, me.c0);
        check("ctl_w1", ctl1, me.c1);
        check("valid_w1", b1.out_valid, 1);
      end
    end
  end

  initial begin
    tbl[0]  = '{32'h00500093, 9'b100100000, 9'b100100000};
    tbl[1]  = '{32'h00728333, 9'b100000000, 9'b100000000};
    tbl[2]  = '{32'h00013283, 9'b110110000, 9'b110110000};
    tbl[3]  = '{32'h12345537, 9'b100100000, 9'b100100000};
    tbl[4]  = '{32'h00512023, 9'b001100000, 9'b001100000};
    tbl[5]  = '{32'h00208463, 9'b000001000, 9'b000001000};
    tbl[6]  = '{32'h010000EF, 9'b100100100, 9'b100100100};
    tbl[7]  = '{32'h00008067, 9'b000100100, 9'b000100100};
    tbl[8]  = '{32'h00001197, 9'b100100000, 9'b100100000};
    tbl[9]  = '{32'h0010809B, 9'b000000001, 9'b100100010};
    tbl[10] = '{32'h0020823B, 9'b000000001, 9'b100000010};
    tbl[11] = '{32'h0000007F, 9'b000000001, 9'b000000001};
    tbl[12] = '{32'h00000013, 9'b000100000, 9'b000100000};
    tbl[13] = '{32'h00500091, 9'b000000001, 9'b000000001};
    b0.in_valid = 1'b0; b0.in_instr = '0; b0.in_pc = '0; b0.flush = 1'b0; b0.out_ready = 1'b1;
    step(); step();
    @(negedge clk);
    check("rst_valid", b0.out_valid, 0);
    check("rst_ctl", ctl0, 0);
    check("rst_pc", b0.out_pc, 0);
    check("rst_cnt", sc0, 0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 14; i++) begin
      logic [XLEN-1:0] pc;
      pc = 64'h8000_0000_0000_1000 + 64'(i * 4);
      offer(tbl[i].instr, pc);
      sb.push_back(mk(tbl[i].instr, pc, tbl[i].c0, tbl[i].c1));
      #1;
      check("tbl_in_ready", b0.in_ready, 1);
      step();
    end
    b0.in_valid = 1'b0;
    step(); step();
    check("tbl_drained", sb.size(), 0);
    check("tbl_no_stall", sc0, 0);
    // load-use: ld x5 then add x6,x5,x7
    offer(32'h00013283, 64'h100);
    sb.push_back(mk(32'h00013283, 64'h100, 9'b110110000, 9'b110110000));
    step();
    offer(32'h00728333, 64'h104);
    #1;
    check("hz_ready", b0.in_ready, 0);
    @(negedge clk);
    check("hz_ld_valid", b0.out_valid, 1);
    step();
    @(negedge clk);
    check("hz_bubble", b0.out_valid, 0);
    check("hz_ready_next", b0.in_ready, 1);
    sb.push_back(mk(32'h00728333, 64'h104, 9'b100000000, 9'b100000000));
    step();
    b0.in_valid = 1'b0;
    @(negedge clk);
    check("hz_add_valid", b0.out_valid, 1);
    check("hz_cnt0", sc0, 1);
    check("hz_cnt1", sc1, 1);
    step();
    // backpressure: sw held while addi waits
    offer(32'h00512023, 64'h200);
    sb.push_back(mk(32'h00512023, 64'h200, 9'b001100000, 9'b001100000));
    step();
    b0.out_ready = 1'b0;
    offer(32'h00500093, 64'h204);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_valid", b0.out_valid, 1);
      check("bp_mem_write", b0.out_mem_write, 1);
      check("bp_pc", b0.out_pc, 64'h200);
      check("bp_ready", b0.in_ready, 0);
      step();
    end
    b0.out_ready = 1'b1;
    sb.push_back(mk(32'h00500093, 64'h204, 9'b100100000, 9'b100100000));
    #1;
    check("bp_release_ready", b0.in_ready, 1);
    step();
    b0.in_valid = 1'b0;
    step(); step();
    check("bp_drained", sb.size(), 0);
    // flush while holding ld with another instruction offered
    offer(32'h00013283, 64'h300);
    step();
    b0.out_ready = 1'b0;
    offer(32'h00500093, 64'h304);
    b0.flush = 1'b1;
    #1;
    check("fl_ready", b0.in_ready, 0);
    step();
    b0.flush = 1'b0;
    b0.in_valid = 1'b0;
    @(negedge clk);
    check("fl_valid", b0.out_valid, 0);
    check("fl_valid_w1", b1.out_valid, 0);
    b0.out_ready = 1'b1;
    step(); step();
    // saturation: held load blocks a dependent add for 2^CNT_W+3 cycles
    offer(32'h00013283, 64'h400);
    step();
    b0.out_ready = 1'b0;
    offer(32'h00728333, 64'h404);
    repeat ((1 << CNT_W) + 3) step();
    @(negedge clk);
    check("sat_cnt0", sc0, {CNT_W{1'b1}});
    check("sat_cnt1", sc1, {CNT_W{1'b1}});
    check("sat_hold_valid", b0.out_valid, 1);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("mid_rst_valid", b0.out_valid, 0);
    check("mid_rst_ctl", ctl0, 0);
    check("mid_rst_rd", b0.out_rd, 0);
    check("mid_rst_pc", b0.out_pc, 0);
    check("mid_rst_cnt", sc0, 0);
    sb.delete();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
